// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : ps2_pkg                                                  |
// | Description : Shared constants for the PS/2 keyboard receiver: frame   |
// |               FSM state encoding, scancode prefix bytes and the set of |
// |               keyboard response bytes that never form a key event.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package ps2_pkg;

    // Frame FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Scancode prefixes
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_REL   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    // Keyboard responses (ack, BAT result, echo, resend, errors) that are
    // silently dropped without touching the prefix flags.
    function automatic logic is_discard(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: hit = 1'b1;
            default:                                   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ps2_line_filter                                          |
// | Description : Two-flop synchroniser followed by a glitch filter for    |
// |               one raw PS/2 line. The filtered output idles high and    |
// |               only changes after FILTER_LEN consecutive synchronised   |
// |               samples disagree with it.                                |
// | Ports       : clk_sys - system clock                                   |
// |               reset   - asynchronous active-high reset                 |
// |               i_line  - raw asynchronous line                          |
// |               o_line  - synchronised, filtered line                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_line,
    output logic o_line
);

    localparam int                 c_CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_LEN - 1);

    logic [1:0]         r_sync;
    logic               r_filt;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            // Any sample that agrees with the current output restarts the run,
            // so only an unbroken run of FILTER_LEN differing samples flips it.
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_line = r_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_key_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ps2_key_rx                                               |
// | Description : PS/2 keyboard receiver. Filters both lines, deserialises |
// |               11-bit frames, checks odd parity and stop bit, folds     |
// |               E0/F0 prefixes into one toggle-strobed key event and     |
// |               swallows the Pause (E1) sequence.                        |
// | Ports       : clk_sys     - system clock                               |
// |               reset       - asynchronous active-high reset             |
// |               ps2_clk_in  - raw PS/2 clock line                        |
// |               ps2_data_in - raw PS/2 data line                         |
// |               ps2_key     - {toggle, pressed, extended, scancode}      |
// |               parity_err  - one-cycle pulse on odd-parity failure      |
// |               frame_err   - one-cycle pulse on start/stop/timeout      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ps2_key_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        parity_err,
    output logic        frame_err
);

    import ps2_pkg::*;

    localparam int                 c_TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT);

    logic               w_clk_f;
    logic               w_data_f;
    logic               r_clk_q;
    logic               w_fall;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_frame_done;
    logic               w_start_err;
    logic               w_timeout;
    logic               w_par_ok;

    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_ext;
    logic               r_rel;
    logic [2:0]         r_skip;
    logic [10:0]        r_key;
    logic               r_parity_err;
    logic               r_frame_err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_line  (ps2_clk_in),
        .o_line  (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_line  (ps2_data_in),
        .o_line  (w_data_f)
    );

    // Falling edge of the filtered clock, valid the cycle after it fell.
    assign w_fall   = r_clk_q & ~w_clk_f;
    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign w_par_ok = ^{r_shift, r_parity};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_q <= 1'b1;
            r_state <= ST_IDLE;
        end else begin
            r_clk_q <= w_clk_f;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        w_start_err  = 1'b0;
        w_timeout    = 1'b0;
        // An edge takes precedence over a timeout landing in the same cycle.
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data_f) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_start_err = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_state_nxt = ST_STOP;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_frame_done = 1'b1;
                end
            endcase
        end else if ((r_state != ST_IDLE) && (r_tmo_cnt == c_TMO_MAX)) begin
            w_state_nxt = ST_IDLE;
            w_timeout   = 1'b1;
        end
    end

    // Inactivity counter: restarted by every edge, frozen while idle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_fall) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != ST_IDLE) && (r_tmo_cnt != c_TMO_MAX)) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_ext        <= 1'b0;
            r_rel        <= 1'b0;
            r_skip       <= 3'd0;
            r_key        <= 11'h000;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= 3'd0;
                    end
                    ST_DATA: begin
                        r_shift   <= {w_data_f, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: begin
                        r_parity <= w_data_f;
                    end
                    default: begin
                    end
                endcase
            end

            // In the stop state the sampled data line is the stop bit itself.
            if (w_start_err || w_timeout || (w_frame_done && !w_data_f)) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_rel       <= 1'b0;
                r_skip      <= 3'd0;
            end else if (w_frame_done && !w_par_ok) begin
                r_parity_err <= 1'b1;
                r_ext        <= 1'b0;
                r_rel        <= 1'b0;
                r_skip       <= 3'd0;
            end else if (w_frame_done) begin
                // Bytes still owed to a Pause sequence are eaten whatever
                // their value, prefixes included.
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else if (r_shift == PFX_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PFX_REL) begin
                    r_rel <= 1'b1;
                end else if (r_shift == PFX_PAUSE) begin
                    r_skip <= 3'd7;
                end else if (!is_discard(r_shift)) begin
                    r_key <= {~r_key[10], ~r_rel, r_ext, r_shift};
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end
            end
        end
    end

    assign ps2_key    = r_key;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_ps2_key_rx                                            |
// | Description : Self-checking bench for ps2_key_rx. Drives PS/2 frames   |
// |               at byte level and compares key words, event count and    |
// |               error pulse counts against a byte-level reference model. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_ps2_key_rx;

    localparam int c_FL   = 4;
    localparam int c_TMO  = 200;
    localparam int c_HALF = 10;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk_in  = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        parity_err;
    logic        frame_err;

    ps2_key_rx #(.FILTER_LEN(c_FL), .TIMEOUT(c_TMO)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_assert = 0;
    int n_fail   = 0;

    // Observed pulse and event counts
    int   n_perr = 0;
    int   n_ferr = 0;
    int   n_evt  = 0;
    logic prev_tog = 1'b0;

    always @(negedge clk_sys) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (!reset && (ps2_key[10] !== prev_tog)) n_evt++;
        prev_tog = ps2_key[10];
    end

    // Byte-level reference model
    logic [10:0] m_key  = 11'h000;
    logic        m_ext  = 1'b0;
    logic        m_rel  = 1'b0;
    int          m_skip = 0;
    int          m_perr = 0;
    int          m_ferr = 0;
    int          m_evt  = 0;
    int          last_lat = 0;

    function automatic void model_clear();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        if (!stop_ok) begin
            m_ferr++;
            model_clear();
        end else if (!par_ok) begin
            m_perr++;
            model_clear();
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
            // response byte, ignored
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_evt++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bit(input logic b);
        ps2_data_in = b;
        idle(c_HALF);
        ps2_clk_in = 1'b0;
        idle(c_HALF);
        ps2_clk_in = 1'b1;
    endtask

    // Full frame; measures cycles from the stop-bit clock fall to the first
    // visible output reaction.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic        p;
        logic [10:0] key0;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        ps2_data_in = ~bad_stop;
        idle(c_HALF);
        key0 = ps2_key;
        ps2_clk_in = 1'b0;
        last_lat = 0;
        for (int i = 1; i <= c_HALF; i++) begin
            @(negedge clk_sys);
            if ((last_lat == 0) && ((ps2_key !== key0) || parity_err || frame_err))
                last_lat = i;
        end
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        idle(c_HALF);
        model_byte(b, !bad_par, !bad_stop);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".key"},  {21'd0, ps2_key}, {21'd0, m_key});
        check({tag, ".perr"}, n_perr, m_perr);
        check({tag, ".ferr"}, n_ferr, m_ferr);
        check({tag, ".evt"},  n_evt,  m_evt);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        idle(4);
        reset = 1'b0;
        m_key = 11'h000;
        model_clear();
        idle(4);
    endtask

    initial begin
        logic [7:0] rb;
        bit         bp;
        bit         bs;
        int         sel;

        // Reset state
        idle(3);
        check("rst.key",  {21'd0, ps2_key}, 32'h0);
        check("rst.perr", {31'd0, parity_err}, 32'h0);
        check("rst.ferr", {31'd0, frame_err}, 32'h0);
        reset = 1'b0;
        idle(5);

        // Plain make code, with output latency after the stop edge
        send_frame(8'h1C, 1'b0, 1'b0);
        check("make.lat", last_lat, c_FL + 3);
        check("make.key", {21'd0, ps2_key}, 32'h61C);
        check_all("make");

        // Break code: F0 gives no event, 1C gives one release event
        send_frame(8'hF0, 1'b0, 1'b0);
        check_all("brk.f0");
        send_frame(8'h1C, 1'b0, 1'b0);
        check("brk.key", {21'd0, ps2_key}, 32'h01C);
        check_all("brk");

        // Extended release from reset, then flags must be clear
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext.key", {21'd0, ps2_key}, 32'h575);
        check_all("ext");
        send_frame(8'h1C, 1'b0, 1'b0);
        check("ext.after", {21'd0, ps2_key}, 32'h21C);

        // Parity error: pulse at the same latency, key held
        send_frame(8'h1C, 1'b1, 1'b0);
        check("par.lat", last_lat, c_FL + 3);
        check_all("par");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("par.next");

        // Bad stop bit and bad start bit both raise frame_err
        send_frame(8'h2B, 1'b0, 1'b1);
        check_all("stop");
        send_bit(1'b1);
        idle(c_HALF);
        m_ferr++;
        model_clear();
        check_all("start");

        // Timeout mid-frame after a release prefix; prefix must be forgotten
        send_frame(8'hF0, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data_in = 1'b1;
        idle(c_TMO + 40);
        m_ferr++;
        model_clear();
        check_all("tmo");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("tmo.next");

        // Short clock glitch on an idle line
        ps2_clk_in = 1'b0;
        idle(c_FL - 1);
        ps2_clk_in = 1'b1;
        idle(20);
        check_all("glitch");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("glitch.next");

        // Asynchronous reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("mid.key",  {21'd0, ps2_key}, 32'h0);
        check("mid.perr", {31'd0, parity_err}, 32'h0);
        check("mid.ferr", {31'd0, frame_err}, 32'h0);
        ps2_data_in = 1'b1;
        ps2_clk_in  = 1'b1;
        idle(4);
        reset = 1'b0;
        m_key = 11'h000;
        model_clear();
        idle(4);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("mid.next", {21'd0, ps2_key}, 32'h61C);
        check_all("mid");

        // Pause sequence is swallowed entirely
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        check_all("pause");
        send_frame(8'h29, 1'b0, 1'b0);
        check_all("pause.next");

        // Randomised byte stream
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 12)      rb = 8'hE0;
            else if (sel < 24) rb = 8'hF0;
            else if (sel < 27) rb = 8'hE1;
            else if (sel < 35) begin
                case ($urandom_range(0, 5))
                    0:       rb = 8'h00;
                    1:       rb = 8'hAA;
                    2:       rb = 8'hEE;
                    3:       rb = 8'hFA;
                    4:       rb = 8'hFE;
                    default: rb = 8'hFF;
                endcase
            end else rb = 8'($urandom_range(1, 8'h83));
            bp = ($urandom_range(0, 99) < 8);
            bs = ($urandom_range(0, 99) < 5);
            send_frame(rb, bp, bs);
            check_all("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
